// File: rtl/alu_stream.sv
// Handshaked ALU stage: combinational operation on valid/ready operands, registered result/flags,
// accumulator operand with optional unsigned saturation, and a completed-transaction counter.
module alu_stream #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       control,
  input  logic             acc_sel,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [SH_W-1:0]  sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign op_a = acc_sel ? acc : in_a;
  assign sh   = in_b[SH_W-1:0];
  assign sum  = {1'b0, op_a} + {1'b0, in_b};
  assign diff = {1'b0, op_a} - {1'b0, in_b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (control)
      3'b000: begin
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        alu_res = (SAT != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end
      3'b001: begin
        // diff[WIDTH] is the borrow of the unsigned subtraction
        alu_c   = diff[WIDTH];
        alu_v   = (op_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        alu_res = (SAT != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      end
      3'b010:  alu_res = op_a & in_b;
      3'b011:  alu_res = op_a | in_b;
      3'b100:  alu_res = op_a ^ in_b;
      3'b101:  alu_res = $unsigned($signed(op_a) >>> sh);
      3'b110:  alu_res = op_a >> sh;
      default: alu_res = in_b;
    endcase
  end

  assign alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      txn_cnt   <= '0;
    end else if (accept) begin
      result    <= alu_res;
      flags     <= alu_flags;
      out_valid <= 1'b1;
      txn_cnt   <= txn_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over the load; operand A above already saw the pre-clear value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc <= '0;
    end else if (clr_acc) begin
      acc <= '0;
    end else if (accept) begin
      acc <= alu_res;
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: two instances (wrap/16-bit counter and saturating/2-bit counter) on shared
// inputs, checked against constant vectors and an arithmetic reference model.
module tb_alu_stream;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic [2:0] control;
  logic       acc_sel, clr_acc, out_ready;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [7:0]  result0, acc0, result1, acc1;
  logic [3:0]  flags0, flags1;
  logic [15:0] txn_cnt0;
  logic [1:0]  txn_cnt1;

  int errors = 0;
  int checks = 0;

  int m_valid;
  int m_res[2];
  int m_flg[2];
  int m_acc[2];
  int m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  alu_stream #(.WIDTH(8), .SAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .control(control), .acc_sel(acc_sel), .clr_acc(clr_acc),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .flags(flags0),
    .acc(acc0), .txn_cnt(txn_cnt0)
  );

  alu_stream #(.WIDTH(8), .SAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .control(control), .acc_sel(acc_sel), .clr_acc(clr_acc),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .flags(flags1),
    .acc(acc1), .txn_cnt(txn_cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input int ctl, input int a, input int b, input int sat,
                                  output int res, output int f);
    int sa, sb, r, c, v, sh;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % 8;
    c = 0;
    v = 0;
    case (ctl)
      0: begin
        r = a + b;
        c = (r > 255) ? 1 : 0;
        v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
        r = r % 256;
        if (sat != 0 && c != 0) r = 255;
      end
      1: begin
        r = a - b;
        c = (a < b) ? 1 : 0;
        v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
        r = (r + 256) % 256;
        if (sat != 0 && c != 0) r = 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa >>> sh) & 255;
      6: r = a >> sh;
      default: r = b;
    endcase
    res = r;
    f = ((r == 0) ? 8 : 0) + ((r >= 128) ? 4 : 0) + c * 2 + v;
  endfunction

  task automatic check_outputs();
    chk("result0", result0, m_res[0]);
    chk("flags0", flags0, m_flg[0]);
    chk("acc0", acc0, m_acc[0]);
    chk("out_valid0", out_valid0, m_valid);
    chk("txn_cnt0", txn_cnt0, m_cnt0);
    chk("result1", result1, m_res[1]);
    chk("flags1", flags1, m_flg[1]);
    chk("acc1", acc1, m_acc[1]);
    chk("out_valid1", out_valid1, m_valid);
    chk("txn_cnt1", txn_cnt1, m_cnt1);
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    for (int k = 0; k < 2; k++) begin
      m_res[k] = 0;
      m_flg[k] = 0;
      m_acc[k] = 0;
    end
  endtask

  // One clock: drive inputs, check in_ready, advance the model, check registered outputs.
  task automatic step(input logic v, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic asel, input logic clr, input logic ordy);
    int rdy, acpt, opa, r, f;
    in_valid = v; control = c; in_a = a; in_b = b;
    acc_sel = asel; clr_acc = clr; out_ready = ordy;
    #1;
    rdy = (m_valid == 0 || ordy) ? 1 : 0;
    chk("in_ready0", in_ready0, rdy);
    chk("in_ready1", in_ready1, rdy);
    acpt = (v && rdy != 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      opa = asel ? m_acc[k] : int'(a);
      ref_alu(int'(c), opa, int'(b), k, r, f);
      if (acpt != 0) begin
        m_res[k] = r;
        m_flg[k] = f;
        m_acc[k] = r;
      end
      if (clr) m_acc[k] = 0;
    end
    if (acpt != 0) begin
      m_cnt0 = (m_cnt0 + 1) % 65536;
      m_cnt1 = (m_cnt1 + 1) % 4;
      m_valid = 1;
    end else if (m_valid != 0 && ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("in_ready0_rst", in_ready0, 1);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    check_outputs();
  endtask

  typedef struct {
    int ctl; int a; int b;
    int r0; int f0;
    int r1; int f1;
  } vec_t;

  vec_t vecs[11];
  int   wrap_exp[5];
  int   acc_exp[3];

  initial begin
    vecs[0]  = '{0, 'hF0, 'h20, 'h10, 4'b0010, 'hFF, 4'b0110};
    vecs[1]  = '{1, 'h80, 'h01, 'h7F, 4'b0001, 'h7F, 4'b0001};
    vecs[2]  = '{6, 'h80, 'h0B, 'h10, 4'b0000, 'h10, 4'b0000};
    vecs[3]  = '{5, 'h80, 'h03, 'hF0, 4'b0100, 'hF0, 4'b0100};
    vecs[4]  = '{2, 'hF0, 'h0F, 'h00, 4'b1000, 'h00, 4'b1000};
    vecs[5]  = '{3, 'hA0, 'h05, 'hA5, 4'b0100, 'hA5, 4'b0100};
    vecs[6]  = '{4, 'h55, 'h55, 'h00, 4'b1000, 'h00, 4'b1000};
    vecs[7]  = '{7, 'h12, 'h80, 'h80, 4'b0100, 'h80, 4'b0100};
    vecs[8]  = '{1, 'h01, 'h02, 'hFF, 4'b0110, 'h00, 4'b1010};
    vecs[9]  = '{0, 'h7F, 'h01, 'h80, 4'b0101, 'h80, 4'b0101};
    vecs[10] = '{0, 'h80, 'h80, 'h00, 4'b1011, 'hFF, 4'b0111};
    wrap_exp = '{1, 2, 3, 0, 1};
    acc_exp  = '{'h0A, 'h0F, 'h14};

    n_rst = 1'b0;
    in_valid = 1'b0; control = 3'd0; in_a = 8'd0; in_b = 8'd0;
    acc_sel = 1'b0; clr_acc = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    check_outputs();

    // Operation table, full throughput
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 3'(vecs[i].ctl), 8'(vecs[i].a), 8'(vecs[i].b), 1'b0, 1'b0, 1'b1);
      chk("vec_result", result0, vecs[i].r0);
      chk("vec_flags", flags0, vecs[i].f0);
      chk("vec_result_sat", result1, vecs[i].r1);
      chk("vec_flags_sat", flags1, vecs[i].f1);
    end
    chk("vec_txn_cnt", txn_cnt0, 11);

    // Reset asserted mid-stall
    step(1'b1, 3'd0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("stall_valid", out_valid0, 1);
    do_reset();

    // Backpressure: beat 1 accepted, two stalled cycles, then beats 2 and 3
    step(1'b1, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("bp_ready", in_ready0, 0);
    chk("bp_hold1", result0, 'h02);
    step(1'b1, 3'd0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("bp_hold2", result0, 'h02);
    step(1'b1, 3'd0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
    chk("bp_beat2", result0, 'h04);
    step(1'b1, 3'd0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1);
    chk("bp_beat3", result0, 'h06);
    chk("bp_txn_cnt", txn_cnt0, 3);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("bp_drained", out_valid0, 0);

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd2, 8'(i), 8'hFF, 1'b0, 1'b0, 1'b1);
      chk("wrap_txn_cnt", txn_cnt1, wrap_exp[i]);
    end

    // Accumulator chain, then clear on an accepting beat
    step(1'b1, 3'd7, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0, 8'hEE, 8'h05, 1'b1, 1'b0, 1'b1);
      chk("acc_result", result0, acc_exp[i]);
    end
    chk("acc_value", acc0, 'h14);
    step(1'b1, 3'd0, 8'hEE, 8'h01, 1'b1, 1'b1, 1'b1);
    chk("clr_result", result0, 'h15);
    chk("clr_acc", acc0, 0);
    chk("clr_acc_sat", acc1, 0);
    // Clear without accept: only acc changes
    step(1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'd1, 8'h77, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("clr_idle_acc", acc0, 0);
    chk("clr_idle_result", result0, 'h01);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_stream.md
Name: alu_stream

Overview:
Parametrised, handshaked successor to the single-register 8-bit ALU stage. Operands enter through a valid/ready interface and are computed combinationally. The result and flags are captured in an output register that holds under backpressure. Adds an internal accumulator operand, optional unsigned saturation, status flags and a completed-transaction counter. Sits between the operand sequencer and the writeback logic.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 4
SAT, 0, 1 = unsigned saturation on add/sub; 0 = wrap-around
CNT_W, 16, width of the transaction counter

Ports:
clk  input  1  clock; all state updates on rising edge
n_rst  input  1  reset, asynchronous, active-low
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
control  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 arithmetic right shift, 110 logical right shift, 111 pass B
acc_sel  input  1  1 = use the accumulator in place of in_a
clr_acc  input  1  synchronous accumulator clear
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream accepts the result
result  output  WIDTH  registered result
flags  output  4  registered {z, n, c, v}
acc  output  WIDTH  accumulator value
txn_cnt  output  CNT_W  number of accepted beats, wrapping

Behaviour:
- Reset (async, n_rst low): result=0, flags=0, out_valid=0, acc=0, txn_cnt=0. Beats in flight are discarded. in_ready is 1 once reset is released.
- in_ready = !out_valid || out_ready. It is combinational and never depends on in_valid.
- Accept = in_valid && in_ready. On accept:
  - result and flags load the ALU output.
  - out_valid is set to 1.
  - txn_cnt increments (wraps at 2^CNT_W-1 -> 0).
  - acc loads the new result.
  - Latency is 1 cycle: the result is visible the cycle after accept.
- Output transfer = out_valid && out_ready. With no accept in the same cycle, out_valid clears. With an accept in the same cycle, out_valid stays 1 and new data loads, giving full throughput of 1 beat/cycle.
- Stall (out_valid=1, out_ready=0): result, flags and out_valid hold. in_ready=0 and the input beat is not consumed.
- Operand A = acc_sel ? acc (current register value) : in_a.
- Shift amount = in_b[log2(WIDTH)-1:0]; upper bits of in_b are ignored. Arithmetic shift sign-fills from A's MSB.
- add:
  - c = carry-out of A+B.
  - v = signed overflow.
  - When SAT=1 and c=1, result = all ones.
- sub:
  - c = borrow (A<B unsigned).
  - v = signed overflow.
  - When SAT=1 and borrow, result = 0.
- Logic, shift and pass ops: c=0, v=0.
- z = (final result == 0). n = final result MSB. Both are computed after saturation.
- clr_acc has priority over the accumulator update: if it is asserted on an accept cycle, acc becomes 0. The result still loads normally, and operand A already used the pre-clear acc.
- clr_acc without accept: acc becomes 0; all other state is unchanged.
- Control or operand changes while in_valid=0 have no effect.

Test Plan:
- Reset with WIDTH=8: n_rst low mid-stall with out_valid=1 -> next edge all outputs 0, in_ready=1.
- add 0xF0+0x20, SAT=0, out_ready=1 -> next cycle result=0x10, flags z0 n0 c1 v0, txn_cnt=1. Same with SAT=1 -> result=0xFF, c1.
- sub 0x80-0x01 -> result=0x7F, v1, c0. Logical right shift 0x80 by in_b=0x0B (low 3 bits=3) -> 0x10. Arithmetic right shift 0x80 by 3 -> 0xF0, n1.
- Backpressure: 3 back-to-back beats, out_ready low for 2 cycles after the first -> in_ready=0 during the stall, result holds beat 1. After release the results emerge in order and txn_cnt=3.
- Accumulator: pass B 0x05, then 3x add acc_sel=1 in_b=0x05 -> results 0x0A, 0x0F, 0x14, acc=0x14. Then clr_acc with an accept add acc_sel=1 in_b=1 -> result 0x15, acc=0.
- Counter wrap with CNT_W=2: 5 accepted beats -> txn_cnt sequence 1,2,3,0,1.
